// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcodes, FSM encoding and opcode helpers.
package alu_pkg;

  localparam logic [4:0] OP_AND  = 5'h00;
  localparam logic [4:0] OP_OR   = 5'h01;
  localparam logic [4:0] OP_ADD  = 5'h02;
  localparam logic [4:0] OP_ADDU = 5'h03;
  localparam logic [4:0] OP_SUBU = 5'h04;
  localparam logic [4:0] OP_SUB  = 5'h06;
  localparam logic [4:0] OP_SLT  = 5'h07;
  localparam logic [4:0] OP_SLTU = 5'h08;
  localparam logic [4:0] OP_NOR  = 5'h0C;
  localparam logic [4:0] OP_XOR  = 5'h0D;
  localparam logic [4:0] OP_SLL  = 5'h10;
  localparam logic [4:0] OP_SRL  = 5'h11;
  localparam logic [4:0] OP_SRA  = 5'h12;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  function automatic logic is_shift(input logic [4:0] control);
    return (control == OP_SLL) || (control == OP_SRL) || (control == OP_SRA);
  endfunction

endpackage

// File: rtl/alu_addsub.sv
// Shared WIDTH-bit adder/subtractor; subtraction is a + ~b + 1 so cout=1 means no borrow.
module alu_addsub #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf_signed
);

  logic [WIDTH-1:0] b_eff_s;

  assign b_eff_s = sub ? ~b : b;
  assign {cout, sum} = {1'b0, a} + {1'b0, b_eff_s} + {{WIDTH{1'b0}}, sub};
  assign ovf_signed = (a[WIDTH-1] == b_eff_s[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

endmodule

// File: rtl/alu_seq.sv
// Clocked ALU with start/busy/finished handshake; shifts iterate one bit position per clock.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [4:0]       control,
  input  logic [WIDTH-1:0] input_a,
  input  logic [WIDTH-1:0] input_b,
  output logic             busy,
  output logic             finished,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             cout,
  output logic             err_overflow,
  output logic             err_invalid_control
);

  localparam logic [SHAMT_W-1:0] CNT_ZERO = {SHAMT_W{1'b0}};
  localparam logic [SHAMT_W-1:0] CNT_ONE  = {{(SHAMT_W-1){1'b0}}, 1'b1};

  state_t             state_r, state_s;
  logic [WIDTH-1:0]   sh_r, sh_s, result_r, result_s;
  logic [SHAMT_W-1:0] cnt_r, cnt_s;
  logic [4:0]         op_r, op_s;
  logic               cout_r, cout_s, ovf_r, ovf_s, inv_r, inv_s;
  logic               fin_r, fin_s, busy_r, busy_s;

  logic [WIDTH-1:0]   sum_s, shifted_s;
  logic               add_cout_s, add_ovf_s, sub_sel_s, out_bit_s, slt_s;
  logic [SHAMT_W-1:0] shamt_s;

  assign shamt_s   = input_b[SHAMT_W-1:0];
  assign sub_sel_s = (control != OP_ADD) && (control != OP_ADDU);
  // Signed less-than: sign of the difference, corrected when the subtraction overflowed.
  assign slt_s     = sum_s[WIDTH-1] ^ add_ovf_s;

  alu_addsub #(.WIDTH(WIDTH)) u_addsub (
    .a          (input_a),
    .b          (input_b),
    .sub        (sub_sel_s),
    .sum        (sum_s),
    .cout       (add_cout_s),
    .ovf_signed (add_ovf_s)
  );

  // One-bit shift step of the captured operand and the bit leaving it.
  always_comb begin
    shifted_s = sh_r;
    out_bit_s = 1'b0;
    case (op_r)
      OP_SLL: begin
        shifted_s = {sh_r[WIDTH-2:0], 1'b0};
        out_bit_s = sh_r[WIDTH-1];
      end
      OP_SRL: begin
        shifted_s = {1'b0, sh_r[WIDTH-1:1]};
        out_bit_s = sh_r[0];
      end
      OP_SRA: begin
        shifted_s = {sh_r[WIDTH-1], sh_r[WIDTH-1:1]};
        out_bit_s = sh_r[0];
      end
      default: begin
        shifted_s = sh_r;
        out_bit_s = 1'b0;
      end
    endcase
  end

  // Next-state and next-output logic for the IDLE/SHIFT controller.
  always_comb begin
    state_s  = state_r;
    sh_s     = sh_r;
    cnt_s    = cnt_r;
    op_s     = op_r;
    result_s = result_r;
    cout_s   = cout_r;
    ovf_s    = ovf_r;
    inv_s    = inv_r;
    fin_s    = 1'b0;
    busy_s   = busy_r;
    case (state_r)
      ST_IDLE: begin
        if (start && is_shift(control) && (shamt_s != CNT_ZERO)) begin
          state_s = ST_SHIFT;
          sh_s    = input_a;
          cnt_s   = shamt_s;
          op_s    = control;
          busy_s  = 1'b1;
        end else if (start) begin
          fin_s  = 1'b1;
          inv_s  = 1'b0;
          cout_s = 1'b0;
          ovf_s  = 1'b0;
          case (control)
            OP_AND:  result_s = input_a & input_b;
            OP_OR:   result_s = input_a | input_b;
            OP_NOR:  result_s = ~(input_a | input_b);
            OP_XOR:  result_s = input_a ^ input_b;
            OP_ADD, OP_SUB: begin
              result_s = sum_s;
              cout_s   = add_cout_s;
              ovf_s    = add_ovf_s;
            end
            OP_ADDU: begin
              result_s = sum_s;
              cout_s   = add_cout_s;
              ovf_s    = add_cout_s;
            end
            OP_SUBU: begin
              result_s = sum_s;
              cout_s   = add_cout_s;
              ovf_s    = ~add_cout_s;
            end
            OP_SLT:  result_s = {{(WIDTH-1){1'b0}}, slt_s};
            OP_SLTU: result_s = {{(WIDTH-1){1'b0}}, ~add_cout_s};
            OP_SLL, OP_SRL, OP_SRA: result_s = input_a;
            default: begin
              // Invalid opcode: flag it but keep the previous result and arithmetic flags.
              inv_s  = 1'b1;
              cout_s = cout_r;
              ovf_s  = ovf_r;
            end
          endcase
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        sh_s  = shifted_s;
        cnt_s = cnt_r - CNT_ONE;
        if (cnt_r == CNT_ONE) begin
          state_s  = ST_IDLE;
          busy_s   = 1'b0;
          fin_s    = 1'b1;
          result_s = shifted_s;
          cout_s   = out_bit_s;
          ovf_s    = 1'b0;
          inv_s    = 1'b0;
        end else begin
          state_s = ST_SHIFT;
        end
      end
      default: begin
        state_s = ST_IDLE;
        busy_s  = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r  <= ST_IDLE;
      sh_r     <= {WIDTH{1'b0}};
      cnt_r    <= CNT_ZERO;
      op_r     <= 5'h00;
      result_r <= {WIDTH{1'b0}};
      cout_r   <= 1'b0;
      ovf_r    <= 1'b0;
      inv_r    <= 1'b0;
      fin_r    <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      sh_r     <= sh_s;
      cnt_r    <= cnt_s;
      op_r     <= op_s;
      result_r <= result_s;
      cout_r   <= cout_s;
      ovf_r    <= ovf_s;
      inv_r    <= inv_s;
      fin_r    <= fin_s;
      busy_r   <= busy_s;
    end
  end

  assign busy                = busy_r;
  assign finished            = fin_r;
  assign result              = result_r;
  assign zero                = (result_r == {WIDTH{1'b0}});
  assign cout                = cout_r;
  assign err_overflow        = ovf_r;
  assign err_invalid_control = inv_r;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: hand-computed vectors checked with immediate assertions.
module tb_alu_seq;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [4:0]  control = 5'h00;
  logic [31:0] input_a = 32'h0;
  logic [31:0] input_b = 32'h0;
  logic        busy, finished, zero, cout, err_overflow, err_invalid_control;
  logic [31:0] result;

  int checks   = 0;
  int failures = 0;
  int fin_seen = 0;

  alu_seq #(.WIDTH(32)) dut (
    .clock               (clock),
    .reset               (reset),
    .start               (start),
    .control             (control),
    .input_a             (input_a),
    .input_b             (input_b),
    .busy                (busy),
    .finished            (finished),
    .result              (result),
    .zero                (zero),
    .cout                (cout),
    .err_overflow        (err_overflow),
    .err_invalid_control (err_invalid_control)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present an op at the next falling edge; returns #1 after the accepting rising edge.
  task automatic apply(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    start   = 1'b1;
    control = op;
    input_a = a;
    input_b = b;
    @(posedge clock);
    #1;
  endtask

  task automatic idle_cycle();
    @(negedge clock);
    start = 1'b0;
    @(posedge clock);
    #1;
  endtask

  task automatic chk_flags(input string tag, input logic [31:0] res, input logic c,
                           input logic ovf, input logic inv, input logic fin);
    chk({tag, "_result"}, result, res);
    chk({tag, "_cout"}, {31'd0, cout}, {31'd0, c});
    chk({tag, "_ovf"}, {31'd0, err_overflow}, {31'd0, ovf});
    chk({tag, "_inv"}, {31'd0, err_invalid_control}, {31'd0, inv});
    chk({tag, "_fin"}, {31'd0, finished}, {31'd0, fin});
  endtask

  initial begin
    repeat (2) @(posedge clock);
    #1;
    chk_flags("reset", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("reset_zero", {31'd0, zero}, 32'd1);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    @(negedge clock);
    reset = 1'b0;

    apply(5'h02, 32'h7FFFFFFF, 32'h00000001);
    chk_flags("add_ovf", 32'h80000000, 1'b0, 1'b1, 1'b0, 1'b1);
    idle_cycle();
    chk("add_fin_clear", {31'd0, finished}, 32'd0);
    chk("add_hold", result, 32'h80000000);

    apply(5'h06, 32'd5, 32'd5);
    chk_flags("sub_eq", 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("sub_zero", {31'd0, zero}, 32'd1);
    apply(5'h04, 32'd3, 32'd5);
    chk_flags("subu_borrow", 32'hFFFFFFFE, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("subu_zero", {31'd0, zero}, 32'd0);

    apply(5'h07, 32'hFFFFFFFF, 32'h00000001);
    chk_flags("slt", 32'h1, 1'b0, 1'b0, 1'b0, 1'b1);
    apply(5'h08, 32'hFFFFFFFF, 32'h00000001);
    chk_flags("sltu", 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    apply(5'h03, 32'hFFFFFFFF, 32'h00000001);
    chk_flags("addu_carry", 32'h0, 1'b1, 1'b1, 1'b0, 1'b1);
    apply(5'h0D, 32'hF0F0F0F0, 32'hFF00FF00);
    chk_flags("xor", 32'h0FF00FF0, 1'b0, 1'b0, 1'b0, 1'b1);
    apply(5'h0C, 32'h0, 32'h0);
    chk_flags("nor", 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b1);
    apply(5'h00, 32'hFFFF0000, 32'h0FF00FF0);
    chk_flags("and", 32'h0FF00000, 1'b0, 1'b0, 1'b0, 1'b1);
    apply(5'h01, 32'hFFFF0000, 32'h0FF00FF0);
    chk_flags("or", 32'hFFFF0FF0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle_cycle();

    // SRA by 4 with a competing start held during busy
    apply(5'h12, 32'h80000000, 32'd4);
    chk("sra_busy0", {31'd0, busy}, 32'd1);
    chk("sra_fin0", {31'd0, finished}, 32'd0);
    for (int i = 1; i < 4; i++) begin
      @(negedge clock);
      start   = 1'b1;
      control = 5'h02;
      input_a = 32'd1;
      input_b = 32'd1;
      @(posedge clock);
      #1;
      chk($sformatf("sra_busy%0d", i), {31'd0, busy}, 32'd1);
      chk($sformatf("sra_fin%0d", i), {31'd0, finished}, 32'd0);
    end
    @(posedge clock);
    #1;
    chk_flags("sra_done", 32'hF8000000, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("sra_busy_end", {31'd0, busy}, 32'd0);
    idle_cycle();

    apply(5'h11, 32'h00000003, 32'd1);
    chk("srl_busy", {31'd0, busy}, 32'd1);
    idle_cycle();
    chk_flags("srl_done", 32'h00000001, 1'b1, 1'b0, 1'b0, 1'b1);

    apply(5'h10, 32'h00000001, 32'd0);
    chk_flags("sll0", 32'h00000001, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("sll0_busy", {31'd0, busy}, 32'd0);

    apply(5'h02, 32'd2, 32'd3);
    chk_flags("add5", 32'd5, 1'b0, 1'b0, 1'b0, 1'b1);
    apply(5'h1F, 32'd7, 32'd9);
    chk_flags("invalid", 32'd5, 1'b0, 1'b0, 1'b1, 1'b1);
    idle_cycle();
    chk("invalid_fin_clear", {31'd0, finished}, 32'd0);

    // Abort an SLL by 20 with reset mid-way
    apply(5'h10, 32'h00000001, 32'd20);
    chk("sll20_busy", {31'd0, busy}, 32'd1);
    @(negedge clock);
    start = 1'b0;
    repeat (5) @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    chk_flags("abort", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_zero", {31'd0, zero}, 32'd1);
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clock);
      #1;
      if (finished) fin_seen++;
    end
    chk("abort_no_fin", fin_seen, 32'd0);
    chk("abort_idle_busy", {31'd0, busy}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
